// File: rtl/dpd_cap_trigger_gen.sv
// Capture trigger sequencer for the DPD capture block: picks a trigger source,
// applies the programmed delay, fires cap_trigger and waits for cap_done, 1..N times.
module dpd_cap_trigger_gen #(
  parameter int DELAY_WIDTH = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   data_clk,
  input  logic                   data_rst,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic                   ext_trig,
  input  logic [31:0]            data_in_0,
  input  logic [31:0]            threshold,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0]   num_caps,
  input  logic                   cap_done,
  output logic                   cap_trigger,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   cap_count,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_EVT  = 3'd1,
    S_DELAY     = 3'd2,
    S_FIRE      = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [31:0]            thr_q, thr_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [CNT_WIDTH-1:0]   cap_count_q, cap_count_d;
  logic                   ext_dly_q, ext_dly_d;
  logic                   done_dly_q, done_dly_d;
  logic [30:0]            ii_q, ii_d;
  logic [30:0]            qq_q, qq_d;
  logic                   pwr_evt_q, pwr_evt_d;
  logic                   cap_trigger_q, cap_trigger_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic signed [15:0]     samp_re, samp_im;
  logic [31:0]            pwr_sum;
  logic                   ext_rise, done_rise, evt;
  logic [CNT_WIDTH-1:0]   num_eff, count_inc;

  assign samp_re   = data_in_0[15:0];
  assign samp_im   = data_in_0[31:16];
  // Squares of signed 16-bit values peak at 2^30, so 31 bits hold them and the sum fits 32 bits.
  assign pwr_sum   = 32'(ii_q) + 32'(qq_q);
  assign ext_rise  = ext_trig & ~ext_dly_q;
  assign done_rise = cap_done & ~done_dly_q;
  assign num_eff   = (num_q == '0) ? CNT_WIDTH'(1) : num_q;
  assign count_inc = cap_count_q + CNT_WIDTH'(1);

  always_comb begin
    evt = 1'b0;
    case (mode_q)
      2'd0:    evt = 1'b1;
      2'd2:    evt = pwr_evt_q;
      default: evt = ext_rise;
    endcase
  end

  // Handshake: arm is a one-cycle request honoured only in IDLE; each capture is
  // acknowledged by a rising edge of cap_done seen after cap_trigger has been issued.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    thr_d         = thr_q;
    dly_d         = dly_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    cap_count_d   = cap_count_q;
    cap_trigger_d = 1'b0;
    done_d        = 1'b0;
    ext_dly_d     = ext_trig;
    done_dly_d    = cap_done;
    ii_d          = 31'(32'(samp_re) * 32'(samp_re));
    qq_d          = 31'(32'(samp_im) * 32'(samp_im));
    pwr_evt_d     = pwr_sum > thr_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d     = S_WAIT_EVT;
            mode_d      = mode;
            thr_d       = threshold;
            dly_d       = delay;
            num_d       = num_caps;
            cap_count_d = '0;
          end
        end
        S_WAIT_EVT: begin
          if (evt) begin
            if (dly_q == '0) begin
              state_d = S_FIRE;
            end else begin
              cnt_d   = dly_q;
              state_d = S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == DELAY_WIDTH'(1)) begin
            state_d = S_FIRE;
          end else begin
            cnt_d = cnt_q - DELAY_WIDTH'(1);
          end
        end
        S_FIRE: begin
          cap_trigger_d = 1'b1;
          state_d       = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_rise) begin
            cap_count_d = count_inc;
            if (count_inc == num_eff) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT_EVT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      state_q       <= S_IDLE;
      mode_q        <= '0;
      thr_q         <= '0;
      dly_q         <= '0;
      num_q         <= '0;
      cnt_q         <= '0;
      cap_count_q   <= '0;
      ext_dly_q     <= 1'b0;
      done_dly_q    <= 1'b0;
      ii_q          <= '0;
      qq_q          <= '0;
      pwr_evt_q     <= 1'b0;
      cap_trigger_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      thr_q         <= thr_d;
      dly_q         <= dly_d;
      num_q         <= num_d;
      cnt_q         <= cnt_d;
      cap_count_q   <= cap_count_d;
      ext_dly_q     <= ext_dly_d;
      done_dly_q    <= done_dly_d;
      ii_q          <= ii_d;
      qq_q          <= qq_d;
      pwr_evt_q     <= pwr_evt_d;
      cap_trigger_q <= cap_trigger_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign cap_trigger = cap_trigger_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cap_count   = cap_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dpd_cap_trigger_gen.sv
// Bench for dpd_cap_trigger_gen: stimulus predicts the cycle of every cap_trigger
// and done pulse from the timing rules; a negedge monitor pops and compares.
module tb_dpd_cap_trigger_gen;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int EW = 31;
  localparam logic [1:0] K_TRIG = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic          data_clk = 1'b0;
  logic          data_rst, arm, abort, ext_trig, cap_done;
  logic [1:0]    mode;
  logic [31:0]   data_in_0, threshold;
  logic [DW-1:0] delay;
  logic [CW-1:0] num_caps;
  logic          cap_trigger, busy, done;
  logic [CW-1:0] cap_count;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   dir_samples[$];

  dpd_cap_trigger_gen #(.DELAY_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .data_clk(data_clk), .data_rst(data_rst), .arm(arm), .abort(abort),
    .mode(mode), .ext_trig(ext_trig), .data_in_0(data_in_0), .threshold(threshold),
    .delay(delay), .num_caps(num_caps), .cap_done(cap_done),
    .cap_trigger(cap_trigger), .busy(busy), .done(done), .cap_count(cap_count),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 data_clk = ~data_clk;
  always @(posedge data_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  task automatic check_pulse(input logic [1:0] kind);
    logic [EW-1:0] act, exp;
    act = {kind, busy, 20'(cyc), cap_count};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: kind=%0d at cyc=%0d cnt=%0d, expected none", kind, cyc, cap_count);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL pulse_check: got kind=%0d busy=%0b cyc=%0d cnt=%0d, expected kind=%0d busy=%0b cyc=%0d cnt=%0d",
                 act[30:29], act[28], act[27:8], act[7:0], exp[30:29], exp[28], exp[27:8], exp[7:0]);
      end
    end
  endtask

  always @(negedge data_clk) begin
    if (cap_trigger) check_pulse(K_TRIG);
    if (done) check_pulse(K_DONE);
  end

  // driver tasks
  task automatic step();
    @(negedge data_clk);
  endtask

  task automatic push_exp(input logic [1:0] k, input logic b, input int c, input int n);
    exp_q.push_back({k, b, 20'(c), CW'(n)});
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint power(input logic [31:0] s);
    logic signed [15:0] re, im;
    re = s[15:0];
    im = s[31:16];
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [15:0] re, im;
    re = 16'($urandom_range(0, 65535) >> $urandom_range(0, 8));
    im = 16'($urandom_range(0, 65535) >> $urandom_range(0, 8));
    return {im, re};
  endfunction

  task automatic scramble();
    mode      = 2'($urandom_range(0, 3));
    delay     = DW'($urandom_range(0, 65535));
    num_caps  = CW'($urandom_range(0, 255));
    threshold = $urandom();
  endtask

  // One full sequence; expected pulse cycles follow from when each event is presented.
  task automatic run_seq(input logic [1:0] m, input int d, input int n, input logic [31:0] thr, input int dg);
    int a, s, e, t, r, ne, cnt, g;
    logic [31:0] smp;
    step();
    arm = 1'b1; mode = m; delay = DW'(d); num_caps = CW'(n); threshold = thr;
    a = cyc + 1;
    step();
    arm = 1'b0;
    scramble();
    ne  = (n == 0) ? 1 : n;
    cnt = 0;
    s   = a;
    for (int k = 0; k < ne; k++) begin
      e = 0;
      case (m)
        2'd0: e = s + 1;
        2'd2: begin
          for (int tr = 0; tr < 8 && e == 0; tr++) begin
            if (dir_samples.size() > 0) smp = dir_samples.pop_front();
            else if (tr == 7) smp = 32'h8000_8000;
            else smp = rand_sample();
            data_in_0 = smp;
            if (power(smp) > longint'(thr)) e = cyc + 3;
            step();
          end
          data_in_0 = '0;
        end
        default: begin
          g = $urandom_range(0, 3);
          repeat (g) step();
          ext_trig = 1'b1;
          e = cyc + 1;
          step();
          ext_trig = 1'b0;
        end
      endcase
      t = e + 1 + d;
      push_exp(K_TRIG, 1'b1, t, cnt);
      while (cyc < t) step();
      arm = 1'b1;
      if (m == 2'd1 || m == 2'd3) ext_trig = 1'b1;
      step();
      arm = 1'b0;
      ext_trig = 1'b0;
      g = (dg < 0) ? $urandom_range(0, 3) : dg;
      repeat (g) step();
      cap_done = 1'b1;
      r = cyc + 1;
      cnt++;
      if (cnt == ne) push_exp(K_DONE, 1'b0, r, cnt);
      step();
      cap_done = 1'b0;
      s = r;
    end
    dir_samples.delete();
    check_now("busy_after_seq", 32'(busy), 32'd0);
    check_now("count_after_seq", 32'(cap_count), 32'(ne));
  endtask

  initial begin
    int a, r;
    logic [31:0] thr;
    data_rst = 1'b1; arm = 1'b0; abort = 1'b0; ext_trig = 1'b0; cap_done = 1'b0;
    mode = '0; data_in_0 = '0; threshold = '0; delay = '0; num_caps = '0;
    repeat (3) step();
    check_now("rst_cap_trigger", 32'(cap_trigger), 32'd0);
    check_now("rst_busy", 32'(busy), 32'd0);
    check_now("rst_done", 32'(done), 32'd0);
    check_now("rst_cap_count", 32'(cap_count), 32'd0);
    check_now("rst_state", 32'(dbg_state), 32'd0);
    data_rst = 1'b0;
    repeat (2) step();

    run_seq(2'd0, 0, 1, 32'h0, 50);
    run_seq(2'd1, 10, 1, 32'h0, -1);
    run_seq(2'd3, 3, 2, 32'h0, -1);
    dir_samples = '{32'h2000_2000, 32'h0000_7000};
    run_seq(2'd2, 0, 1, 32'h1000_0000, -1);
    dir_samples = '{32'h0000_4000, 32'h8000_8000};
    run_seq(2'd2, 0, 1, 32'h1000_0000, -1);
    run_seq(2'd0, 4, 3, 32'h0, 0);
    run_seq(2'd0, 2, 0, 32'h0, -1);

    // abort while counting down the second capture's delay
    step();
    arm = 1'b1; mode = 2'd0; delay = DW'(6); num_caps = CW'(2);
    a = cyc + 1;
    push_exp(K_TRIG, 1'b1, a + 8, 0);
    step();
    arm = 1'b0;
    while (cyc < a + 8) step();
    step();
    cap_done = 1'b1;
    r = cyc + 1;
    step();
    cap_done = 1'b0;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_now("abort_busy", 32'(busy), 32'd0);
    check_now("abort_count", 32'(cap_count), 32'd1);
    check_now("abort_state", 32'(dbg_state), 32'd0);
    check_now("abort_cyc", 32'(cyc), 32'(r + 3));
    repeat (12) step();

    // arm and abort together: stay idle, count untouched
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check_now("arm_abort_busy", 32'(busy), 32'd0);
    step();
    check_now("arm_abort_count", 32'(cap_count), 32'd1);

    // reset while waiting for cap_done
    step();
    arm = 1'b1; mode = 2'd0; delay = '0; num_caps = CW'(1);
    a = cyc + 1;
    push_exp(K_TRIG, 1'b1, a + 2, 0);
    step();
    arm = 1'b0;
    while (cyc < a + 3) step();
    data_rst = 1'b1;
    step();
    data_rst = 1'b0;
    check_now("midrst_busy", 32'(busy), 32'd0);
    check_now("midrst_trig", 32'(cap_trigger), 32'd0);
    check_now("midrst_done", 32'(done), 32'd0);
    check_now("midrst_count", 32'(cap_count), 32'd0);
    cap_done = 1'b1;
    step();
    cap_done = 1'b0;
    repeat (4) step();

    // randomized sequences
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       thr = 32'h1000_0000;
        1:       thr = $urandom_range(0, 32'h7FFF_FFFF);
        default: thr = 32'h7FFF_FFFF;
      endcase
      run_seq(2'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 3), thr, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    check_now("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
